// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: per-frame digit snapshot, leading-zero
// blanking, per-slot dead time, registered anode/segment outputs.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZ_BLANK     = 1'b1,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       enable,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int          CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);
    localparam logic [3:0]  AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_div_cnt;
    logic [3:0][3:0]    r_shadow;
    logic               r_fresh;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_frame;

    logic               w_slot_end;
    logic               w_z3, w_z32, w_z321;
    logic [3:0]         w_digit;
    logic [3:0]         w_sel;
    logic               w_blank;
    logic               w_lit;
    logic [3:0]         w_an_ah;
    logic [6:0]         w_seg_ah;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    always_comb begin
        w_slot_end = (r_div_cnt == LAST);
        // Zero tests run from the top digit down; A-F compare as nonzero.
        w_z3   = (r_shadow[3] == 4'd0);
        w_z32  = w_z3  && (r_shadow[2] == 4'd0);
        w_z321 = w_z32 && (r_shadow[1] == 4'd0);
        w_digit = r_shadow[0];
        w_sel   = 4'b0001;
        w_blank = 1'b0;
        case (r_state)
            DIG0: begin w_digit = r_shadow[0]; w_sel = 4'b0001; w_blank = 1'b0;              end
            DIG1: begin w_digit = r_shadow[1]; w_sel = 4'b0010; w_blank = LZ_BLANK && w_z321; end
            DIG2: begin w_digit = r_shadow[2]; w_sel = 4'b0100; w_blank = LZ_BLANK && w_z32;  end
            DIG3: begin w_digit = r_shadow[3]; w_sel = 4'b1000; w_blank = LZ_BLANK && w_z3;   end
            default: ;
        endcase
        w_lit    = (r_div_cnt >= BLANK) && enable && !w_blank;
        w_an_ah  = w_lit ? w_sel : 4'h0;
        w_seg_ah = w_lit ? f_decode(w_digit) : 7'h00;
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= DIG0;
            r_div_cnt <= '0;
            r_shadow  <= '0;
            r_fresh   <= 1'b0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_OFF;
            r_frame   <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_div_cnt <= '0;
                case (r_state)
                    DIG0:    r_state <= DIG1;
                    DIG1:    r_state <= DIG2;
                    DIG2:    r_state <= DIG3;
                    default: begin
                        r_state  <= DIG0;
                        r_shadow <= {thousands, hundreds, tens, ones};
                    end
                endcase
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            // r_fresh marks the first DIG0 cycle after a capture; output lags it by one like an/seg.
            r_fresh <= w_slot_end && (r_state == DIG3);
            r_frame <= r_fresh;
            r_an    <= ACTIVE_LOW ? ~w_an_ah  : w_an_ah;
            r_seg   <= ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = ACTIVE_LOW ? 1'b1 : 1'b0;
    assign frame_start = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle model feeding a scoreboard queue, a decode/blanking
// vector table, and hand sequences for reset, snapshot, enable and async reset.
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d_on = 4'd0, d_te = 4'd0, d_hu = 4'd0, d_th = 4'd0;
    logic       en = 1'b1;
    logic [3:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       dp1, dp0, fs1, fs0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b1), .ACTIVE_LOW(1'b1)) u_lz1 (
        .clk_100MHz(clk), .reset_n(rst_n), .ones(d_on), .tens(d_te), .hundreds(d_hu),
        .thousands(d_th), .enable(en), .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1));

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .LZ_BLANK(1'b0), .ACTIVE_LOW(1'b1)) u_lz0 (
        .clk_100MHz(clk), .reset_n(rst_n), .ones(d_on), .tens(d_te), .hundreds(d_hu),
        .thousands(d_th), .enable(en), .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0));

    typedef struct {
        logic [3:0] an1;
        logic [6:0] seg1;
        logic [3:0] an0;
        logic [6:0] seg0;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [3:0]      th, hu, te, on;
        logic [3:0][6:0] s1;
        logic [3:0][6:0] s0;
    } vec_t;

    logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    exp_t       sb_q [$];
    int         m_div = 0, m_idx = 0;
    logic [3:0] m_sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic       m_fresh = 1'b0;
    int         c = 0;
    int         errs = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void model_out(input bit lz, output logic [3:0] a, output logic [6:0] s);
        bit blank;
        blank = 1'b0;
        if (lz) begin
            case (m_idx)
                1: blank = (m_sh[3] == 0) && (m_sh[2] == 0) && (m_sh[1] == 0);
                2: blank = (m_sh[3] == 0) && (m_sh[2] == 0);
                3: blank = (m_sh[3] == 0);
                default: blank = 1'b0;
            endcase
        end
        if (m_div >= BL && en && !blank) begin
            a = ~(4'b0001 << m_idx);
            s = ~DEC[m_sh[m_idx]];
        end else begin
            a = 4'hF;
            s = 7'h7F;
        end
    endfunction

    function automatic void model_reset();
        m_div = 0; m_idx = 0; m_fresh = 1'b0;
        for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
    endfunction

    // Expectation is pushed at the edge from pre-edge state, then popped and compared mid-cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_out(1'b1, e.an1, e.seg1);
        model_out(1'b0, e.an0, e.seg0);
        e.fs = m_fresh;
        m_fresh = (m_div == RD - 1) && (m_idx == 3);
        if (m_div == RD - 1) begin
            if (m_idx == 3) m_sh = '{d_on, d_te, d_hu, d_th};
            m_idx = (m_idx + 1) % 4;
            m_div = 0;
        end else begin
            m_div++;
        end
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("sb_lz1", {an1, seg1, dp1, fs1}, {e.an1, e.seg1, 1'b1, e.fs});
        chk("sb_lz0", {an0, seg0, dp0, fs0}, {e.an0, e.seg0, 1'b1, e.fs});
        c++;
    endtask

    task automatic wait_frame(output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            tick();
            n++;
            if (fs1) found = 1'b1;
        end
        chk("frame_seen", {31'd0, found}, 32'd1);
        c = 0;
    endtask

    task automatic run_to(input int t);
        while (c < t) tick();
    endtask

    task automatic set_in(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te, input logic [3:0] on);
        d_th = th; d_hu = hu; d_te = te; d_on = on;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [7];
        int         n, fcount;
        logic [3:0] exp_an;

        tbl[0] = '{4'd1, 4'd0, 4'd0, 4'd0, {7'h79, 7'h40, 7'h40, 7'h40}, {7'h79, 7'h40, 7'h40, 7'h40}};
        tbl[1] = '{4'd0, 4'd0, 4'd0, 4'd7, {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h78}};
        tbl[2] = '{4'd0, 4'd2, 4'd0, 4'd5, {7'h7F, 7'h24, 7'h40, 7'h12}, {7'h40, 7'h24, 7'h40, 7'h12}};
        tbl[3] = '{4'd9, 4'd8, 4'd6, 4'd4, {7'h10, 7'h00, 7'h02, 7'h19}, {7'h10, 7'h00, 7'h02, 7'h19}};
        tbl[4] = '{4'd0, 4'd0, 4'hA, 4'd0, {7'h7F, 7'h7F, 7'h3F, 7'h40}, {7'h40, 7'h40, 7'h3F, 7'h40}};
        tbl[5] = '{4'd0, 4'd0, 4'd0, 4'd0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
        tbl[6] = '{4'hF, 4'd3, 4'hC, 4'd1, {7'h3F, 7'h30, 7'h3F, 7'h79}, {7'h3F, 7'h30, 7'h3F, 7'h79}};

        // Reset held with 1000 on the inputs.
        set_in(4'd1, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_an",  {28'd0, an1}, 32'hF);
        chk("rst_seg", {25'd0, seg1}, 32'h7F);
        chk("rst_dp",  {31'd0, dp1}, 32'd1);
        chk("rst_fs",  {31'd0, fs1}, 32'd0);
        chk("rst_an_lz0", {28'd0, an0}, 32'hF);
        rst_n = 1'b1;
        model_reset();
        c = 0;
        fcount = 0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (fs1) fcount++;
            if (e == 3) chk("boot_ones0", {an1, seg1}, {4'hE, 7'h40});
        end
        chk("boot_no_frame", fcount, 0);
        tick();
        chk("boot_frame33", {31'd0, fs1}, 32'd1);

        // Decode and blanking table, one lit sample per digit slot.
        for (int v = 0; v < 7; v++) begin
            set_in(tbl[v].th, tbl[v].hu, tbl[v].te, tbl[v].on);
            tick(); tick();
            wait_frame(n);
            for (int i = 0; i < 4; i++) begin
                run_to(8 * i + 4);
                exp_an = (tbl[v].s1[i] == 7'h7F) ? 4'hF : ~(4'b0001 << i);
                chk($sformatf("vec%0d_d%0d_lz1", v, i), {an1, seg1}, {exp_an, tbl[v].s1[i]});
                exp_an = (tbl[v].s0[i] == 7'h7F) ? 4'hF : ~(4'b0001 << i);
                chk($sformatf("vec%0d_d%0d_lz0", v, i), {an0, seg0}, {exp_an, tbl[v].s0[i]});
            end
        end

        // Snapshot isolation, then a change in the same cycle as the DIG3 slot end.
        set_in(4'd0, 4'd0, 4'd0, 4'd3);
        tick(); tick();
        wait_frame(n);
        run_to(4);
        chk("snap_ones3", {an1, seg1}, {4'hE, 7'h30});
        run_to(10);
        d_on = 4'd4;
        wait_frame(n);
        chk("snap_frame_gap", n, 22);
        run_to(4);
        chk("snap_ones4", {an1, seg1}, {4'hE, 7'h19});
        run_to(30);
        d_on = 4'd5;
        wait_frame(n);
        run_to(4);
        chk("snap_edge_ones5", {an1, seg1}, {4'hE, 7'h12});

        // Invalid digit and enable drop across a slot boundary.
        set_in(4'd1, 4'd2, 4'd3, 4'hA);
        tick(); tick();
        wait_frame(n);
        run_to(4);
        chk("inv_dash", {an1, seg1}, {4'hE, 7'h3F});
        en = 1'b0;
        run_to(5);
        chk("en_off", {an1, seg1}, {4'hF, 7'h7F});
        run_to(9);
        en = 1'b1;
        run_to(10);
        chk("en_relit", {an1, seg1}, {4'hD, 7'h30});
        wait_frame(n);
        chk("en_phase", n, 22);

        // Async reset pulse in a DIG2 lit cycle.
        run_to(20);
        chk("pre_rst_dig2", {an1, seg1}, {4'hB, 7'h24});
        #1 rst_n = 1'b0;
        #1;
        chk("async_an",  {28'd0, an1}, 32'hF);
        chk("async_seg", {25'd0, seg1}, 32'h7F);
        chk("async_fs",  {31'd0, fs1}, 32'd0);
        #2 rst_n = 1'b1;
        model_reset();
        c = 0;
        run_to(3);
        chk("post_rst_shadow0", {an1, seg1}, {4'hE, 7'h40});
        wait_frame(n);
        chk("post_rst_frame", n, 30);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
